wb_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one Wishbone classic slave port among NUM_M masters
//  (e.g. UART bridge master + on-chip test master) in the uartwb subsystem.

---
 rtl/wb_arb_pkg.sv | 23 ++
 rtl/wb_arb_rr_pick.sv | 34 +++
 rtl/wb_rr_arbiter.sv | 169 ++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone round-robin arbiter.
package wb_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Read data returned to a master whose cycle was aborted by the timeout.
  localparam int unsigned     TO_DATA_W = 64;
  localparam logic [63:0]     TO_DATA   = '1;

  localparam int unsigned TO_CYC_DEF = 255;
  localparam int unsigned TO_CNT_W   = $clog2(TO_CYC_DEF + 1);

  // Timeout counter is at least 8 bits wide, wider if the limit needs it.
  function automatic int unsigned to_cnt_width(input int unsigned to_cyc);
    int unsigned w;
    w = $clog2(to_cyc + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Round-robin pick: first requester after the last winner, scanning upwards
// with wrap-around. Purely combinational.
module wb_arb_rr_pick #(
  parameter int unsigned NUM_M = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [NUM_M-1:0] win_oh,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_vld
);

  int unsigned idx;
  logic        found;

  // Scan last+1 .. last+NUM_M (mod NUM_M); the first set request wins.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 1; i <= NUM_M; i++) begin
      idx = (32'(last) + i) % NUM_M;
      if (!found && req[idx]) begin
        found       = 1'b1;
        win_oh[idx] = 1'b1;
        win_idx     = IDX_W'(idx);
      end
    end
    win_vld = found;
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic slave among NUM_M masters.
// One grant per cyc-delimited bus cycle, with one idle cycle between grants.
// Optional slave timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_M    = 2,
  parameter int unsigned ADDR_WID = 32,
  parameter int unsigned DATA_WID = 32,
  parameter int unsigned TO_CYC   = TO_CYC_DEF
) (
  input  logic                      clk_i,
  input  logic                      nrst_i,
  input  logic [NUM_M*ADDR_WID-1:0] m_wb_addr_i,
  input  logic [NUM_M*DATA_WID-1:0] m_wb_data_i,
  output logic [NUM_M*DATA_WID-1:0] m_wb_data_o,
  input  logic [NUM_M-1:0]          m_wb_we_i,
  input  logic [NUM_M-1:0]          m_wb_cyc_i,
  input  logic [NUM_M-1:0]          m_wb_stb_i,
  output logic [NUM_M-1:0]          m_wb_ack_o,
  output logic [ADDR_WID-1:0]       s_wb_addr_o,
  output logic [DATA_WID-1:0]       s_wb_data_o,
  input  logic [DATA_WID-1:0]       s_wb_data_i,
  output logic                      s_wb_we_o,
  output logic                      s_wb_cyc_o,
  output logic                      s_wb_stb_o,
  input  logic                      s_wb_ack_i,
  output logic [NUM_M-1:0]          grant_o,
  output logic                      to_flag_o
);

  localparam int unsigned IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  if (NUM_M < 2 || NUM_M > 8 || DATA_WID > TO_DATA_W || TO_CYC == 0) begin : g_param_err
    $error("wb_rr_arbiter: unsupported parameter set");
  end

  arb_state_t          state_q;
  logic [NUM_M-1:0]    grant_q;
  logic [IDX_W-1:0]    last_q;
  logic [NUM_M-1:0]    win_oh;
  logic [IDX_W-1:0]    win_idx;
  logic                win_vld;
  logic                in_grant;
  logic                to_hit;
  logic                gnt_cyc;
  logic                gnt_stb;
  logic                gnt_we;
  logic [ADDR_WID-1:0] gnt_addr;
  logic [DATA_WID-1:0] gnt_wdat;

  wb_arb_rr_pick #(
    .NUM_M (NUM_M),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (m_wb_cyc_i),
    .last    (last_q),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  assign in_grant = (state_q == ST_GRANT);
  assign grant_o  = grant_q;

  // Arbitration FSM: latch a winner from IDLE, release when its cyc drops.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_M - 1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_vld) begin
            grant_q <= win_oh;
            last_q  <= win_idx;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!gnt_cyc || to_hit) begin
            grant_q <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Select the granted master's request signals (all zero when no grant).
  always_comb begin
    gnt_cyc  = 1'b0;
    gnt_stb  = 1'b0;
    gnt_we   = 1'b0;
    gnt_addr = '0;
    gnt_wdat = '0;
    for (int unsigned k = 0; k < NUM_M; k++) begin
      if (grant_q[k]) begin
        gnt_cyc  = m_wb_cyc_i[k];
        gnt_stb  = m_wb_stb_i[k];
        gnt_we   = m_wb_we_i[k];
        gnt_addr = m_wb_addr_i[k*ADDR_WID +: ADDR_WID];
        gnt_wdat = m_wb_data_i[k*DATA_WID +: DATA_WID];
      end
    end
  end

  // Slave side: driven only while granted; a timeout abort drops cyc/stb.
  always_comb begin
    s_wb_cyc_o  = in_grant && gnt_cyc && !to_hit;
    s_wb_stb_o  = in_grant && gnt_stb && !to_hit;
    s_wb_we_o   = in_grant && gnt_we;
    s_wb_addr_o = in_grant ? gnt_addr : '0;
    s_wb_data_o = in_grant ? gnt_wdat : '0;
  end

  // Master side: only the granted master sees ack/data; IDLE acks are dropped.
  always_comb begin
    m_wb_ack_o  = '0;
    m_wb_data_o = '0;
    if (in_grant) begin
      for (int unsigned k = 0; k < NUM_M; k++) begin
        if (grant_q[k]) begin
          m_wb_ack_o[k] = to_hit | s_wb_ack_i;
          m_wb_data_o[k*DATA_WID +: DATA_WID] = to_hit ? TO_DATA[DATA_WID-1:0] : s_wb_data_i;
        end
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = to_cnt_width(TO_CYC);

  logic [CNT_W-1:0] to_cnt_q;
  logic             to_flag_q;

  assign to_hit    = in_grant && (to_cnt_q == CNT_W'(TO_CYC));
  assign to_flag_o = to_flag_q;

  // Stall counter: counts strobed cycles without ack; cleared in IDLE and on ack.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      to_cnt_q <= '0;
    end else if (!in_grant || s_wb_ack_i || to_hit) begin
      to_cnt_q <= '0;
    end else if (gnt_stb) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      to_flag_q <= 1'b0;
    end else if (to_hit) begin
      to_flag_q <= 1'b1;
    end
  end
`else
  assign to_hit    = 1'b0;
  assign to_flag_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: two masters, 1-cycle-ack slave model,
// scoreboards for read data and grant order.
module tb_wb_rr_arbiter;

  localparam int unsigned NM = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic           clk = 1'b0;
  logic           nrst_i;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [NM*DW-1:0] m_rdata;
  logic [NM-1:0]  m_we, m_cyc, m_stb, m_ack;
  logic [AW-1:0]  s_addr;
  logic [DW-1:0]  s_wdata, s_rdata, s_rd;
  logic           s_we, s_cyc, s_stb, s_ack;
  logic [NM-1:0]  grant;
  logic           to_flag;
  logic           hang;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;

  int n_checks = 0;
  int n_errors = 0;
  int ack_cnt [NM];

  logic [DW-1:0] exp_q0 [$];
  logic [DW-1:0] exp_q1 [$];
  logic [NM-1:0] exp_gnt [$];

  always #5 clk = ~clk;

  wb_rr_arbiter #(
    .NUM_M    (NM),
    .ADDR_WID (AW),
    .DATA_WID (DW),
    .TO_CYC   (8)
  ) dut (
    .clk_i       (clk),
    .nrst_i      (nrst_i),
    .m_wb_addr_i (m_addr),
    .m_wb_data_i (m_wdata),
    .m_wb_data_o (m_rdata),
    .m_wb_we_i   (m_we),
    .m_wb_cyc_i  (m_cyc),
    .m_wb_stb_i  (m_stb),
    .m_wb_ack_o  (m_ack),
    .s_wb_addr_o (s_addr),
    .s_wb_data_o (s_wdata),
    .s_wb_data_i (s_rdata),
    .s_wb_we_o   (s_we),
    .s_wb_cyc_o  (s_cyc),
    .s_wb_stb_o  (s_stb),
    .s_wb_ack_i  (s_ack),
    .grant_o     (grant),
    .to_flag_o   (to_flag)
  );

  // Slave model: ack one cycle after cyc&stb, held one cycle, read data = addr+1.
  always @(posedge clk or negedge nrst_i) begin
    if (!nrst_i) begin
      s_ack   <= 1'b0;
      s_rd    <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      s_ack <= !hang && s_cyc && s_stb && !s_ack;
      s_rd  <= s_addr + 1;
      if (s_ack && s_cyc && s_we) begin
        wr_addr <= s_addr;
        wr_data <= s_wdata;
      end
    end
  end
  assign s_rdata = s_ack ? s_rd : '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int m, input logic [DW-1:0] d);
    if (m == 0) exp_q0.push_back(d);
    else        exp_q1.push_back(d);
  endtask

  // One Wishbone classic cycle of 'beats' strobes at a fixed address.
  task automatic wb_cycle(input int m, input int beats, input logic we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    int n;
    @(posedge clk); #1;
    m_addr[m*AW +: AW]  = addr;
    m_wdata[m*DW +: DW] = wdata;
    m_we[m]  = we;
    m_cyc[m] = 1'b1;
    m_stb[m] = 1'b1;
    for (int b = 0; b < beats; b++) begin
      push_exp(m, addr + 1);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!m_ack[m] && n < 200);
      check("ack_wait", 64'(m_ack[m]), 64'd1);
      @(posedge clk); #1;
    end
    m_cyc[m] = 1'b0;
    m_stb[m] = 1'b0;
    m_we[m]  = 1'b0;
  endtask

  // Monitor: grant order/hold, ack ownership, read-data scoreboard.
  initial begin
    logic [NM-1:0] prev_gnt;
    logic [DW-1:0] e;
    prev_gnt = '0;
    forever begin
      @(negedge clk);
      if (nrst_i) begin
        if (grant != 0 && prev_gnt == 0) begin
          if (exp_gnt.size() == 0) check("gnt_extra", 64'(grant), 64'd0);
          else                     check("gnt_order", 64'(grant), 64'(exp_gnt.pop_front()));
        end else if (grant != 0 && grant != prev_gnt) begin
          check("gnt_hold", 64'(grant), 64'(prev_gnt));
        end
        if (|m_ack) begin
          check("ack_owner", 64'(m_ack & ~grant), 64'd0);
          for (int m = 0; m < NM; m++) begin
            if (m_ack[m]) begin
              ack_cnt[m]++;
              if ((m == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                check("ack_extra", 64'(m_ack[m]), 64'd0);
              end else begin
                e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                check(m == 0 ? "rdata_m0" : "rdata_m1", 64'(m_rdata[m*DW +: DW]), 64'(e));
              end
            end else if (!grant[m]) begin
              check("data_iso", 64'(m_rdata[m*DW +: DW]), 64'd0);
            end
          end
        end
      end
      prev_gnt = grant;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, n;
    nrst_i = 1'b0;
    hang   = 1'b0;
    m_addr = '0; m_wdata = '0; m_we = '0; m_cyc = '0; m_stb = '0;
    ack_cnt[0] = 0; ack_cnt[1] = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_scyc",  64'({s_cyc, s_stb, s_we}), 64'd0);
    check("rst_ack",   64'(m_ack), 64'd0);
    check("rst_mdata", 64'(m_rdata), 64'd0);
    check("rst_flag",  64'(to_flag), 64'd0);
    @(posedge clk); #1 nrst_i = 1'b1;

    // Single master 0 write
    a0 = ack_cnt[0]; a1 = ack_cnt[1];
    exp_gnt.push_back(2'b01);
    wb_cycle(0, 1, 1'b1, 32'd1, 32'hA5A5_A5A5);
    repeat (3) @(negedge clk);
    check("wr_addr", 64'(wr_addr), 64'd1);
    check("wr_data", 64'(wr_data), 64'hA5A5_A5A5);
    check("wr_ack_m0", 64'(ack_cnt[0] - a0), 64'd1);
    check("wr_ack_m1", 64'(ack_cnt[1] - a1), 64'd0);
    check("idle_grant", 64'(grant), 64'd0);

    // Both masters request continuously; master 0 won last, so master 1 leads
    for (int i = 0; i < 4; i++) begin
      exp_gnt.push_back(2'b10);
      exp_gnt.push_back(2'b01);
    end
    a0 = ack_cnt[0]; a1 = ack_cnt[1];
    fork
      for (int i = 0; i < 4; i++) wb_cycle(0, 1, 1'b0, 32'h100 + 32'($urandom_range(0, 255)), '0);
      for (int i = 0; i < 4; i++) wb_cycle(1, 1, 1'b0, 32'h200 + 32'($urandom_range(0, 255)), '0);
    join
    repeat (3) @(negedge clk);
    check("rr_ack_m0", 64'(ack_cnt[0] - a0), 64'd4);
    check("rr_ack_m1", 64'(ack_cnt[1] - a1), 64'd4);

    // m1 burst of 3 reads at addr 5; m0 blips cyc (ignored), then waits its turn
    exp_gnt.push_back(2'b10);
    exp_gnt.push_back(2'b01);
    a0 = ack_cnt[0]; a1 = ack_cnt[1];
    fork
      wb_cycle(1, 3, 1'b0, 32'd5, '0);
      begin
        repeat (3) @(posedge clk);
        #1 m_cyc[0] = 1'b1;
        @(posedge clk);
        #1 m_cyc[0] = 1'b0;
        repeat (2) @(posedge clk);
        wb_cycle(0, 1, 1'b0, 32'h40, '0);
      end
    join
    repeat (3) @(negedge clk);
    check("burst_ack_m1", 64'(ack_cnt[1] - a1), 64'd3);
    check("burst_ack_m0", 64'(ack_cnt[0] - a0), 64'd1);

    // Hung slave on master 0
    hang = 1'b1;
    exp_gnt.push_back(2'b01);
    a0 = ack_cnt[0];
    @(posedge clk); #1;
    m_addr[0 +: AW] = 32'h77;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
    push_exp(0, 32'hFFFF_FFFF);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_ack[0] && n < 100);
    check("to_latency", 64'(n), 64'd10);
    check("to_scyc", 64'({s_cyc, s_stb}), 64'd0);
    @(posedge clk); #1;
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    @(negedge clk);
    check("to_flag_set", 64'(to_flag), 64'd1);
    check("to_acks", 64'(ack_cnt[0] - a0), 64'd1);
`else
    repeat (1000) @(negedge clk);
    check("hang_acks", 64'(ack_cnt[0] - a0), 64'd0);
    check("hang_flag", 64'(to_flag), 64'd0);
    check("hang_grant", 64'(grant), 64'd1);
    @(posedge clk); #1;
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // Reset asserted mid-GRANT clears outputs immediately
    exp_gnt.push_back(2'b01);
    @(posedge clk); #1;
    m_addr[0 +: AW] = 32'h88;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_scyc", 64'(s_cyc), 64'd1);
    #2 nrst_i = 1'b0;
    #1;
    check("mid_rst_scyc", 64'(s_cyc), 64'd0);
    check("mid_rst_grant", 64'(grant), 64'd0);
    check("mid_rst_ack", 64'(m_ack), 64'd0);
    check("mid_rst_flag", 64'(to_flag), 64'd0);
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    hang = 1'b0;
    @(posedge clk); #1 nrst_i = 1'b1;

    // After reset, master 0 wins a simultaneous request first
    exp_gnt.push_back(2'b01);
    exp_gnt.push_back(2'b10);
    fork
      wb_cycle(0, 1, 1'b0, 32'h10, '0);
      wb_cycle(1, 1, 1'b0, 32'h20, '0);
    join
    repeat (5) @(negedge clk);

    check("sb_left_m0", 64'(exp_q0.size()), 64'd0);
    check("sb_left_m1", 64'(exp_q1.size()), 64'd0);
    check("sb_left_gnt", 64'(exp_gnt.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
